// File: rtl/pc_sequencer.sv
// Program-counter sequencer: sequential/redirect PC selection with a one-deep
// redirect buffer for stalls, plus a circular return-address stack.
module pc_sequencer #(
  parameter int unsigned      WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VEC = '0,
  parameter int unsigned      INC       = 4,
  parameter int unsigned      RAS_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           stall,
  input  logic                           beq,
  input  logic [WIDTH-1:0]               pc_branch,
  input  logic                           jmp,
  input  logic [WIDTH-1:0]               pc_jmp,
  input  logic                           jr,
  input  logic [WIDTH-1:0]               pc_reg,
  input  logic                           link,
  input  logic [WIDTH-1:0]               link_addr,
  input  logic                           ret,
  output logic [WIDTH-1:0]               pc,
  output logic [WIDTH-1:0]               pc_plus,
  output logic                           pending,
  output logic [WIDTH-1:0]               ras_top,
  output logic [$clog2(RAS_DEPTH+1)-1:0] ras_count,
  output logic                           ras_underflow
);

  localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);
  localparam int unsigned PTR_W = $clog2(RAS_DEPTH);

  typedef enum logic {S_RUN, S_PEND} state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] pc_n, tgt_q, tgt_n, sel_tgt, top_n;
  logic             redirect;
  logic [PTR_W-1:0] ptr, ptr_n, ptr_inc, ptr_dec, waddr;
  logic [CNT_W-1:0] cnt_n;
  logic             ras_we, uf_n;
  logic [WIDTH-1:0] ras_mem [RAS_DEPTH];

  assign pc_plus  = pc + WIDTH'(INC);
  assign pending  = (state == S_PEND);
  assign redirect = jr | jmp | beq;
  assign ptr_inc  = (ptr == PTR_W'(RAS_DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
  assign ptr_dec  = (ptr == '0) ? PTR_W'(RAS_DEPTH - 1) : ptr - PTR_W'(1);

  // Redirect priority: jr > jmp > beq, else fall through sequentially.
  always_comb begin
    sel_tgt = pc_plus;
    if (jr)       sel_tgt = pc_reg;
    else if (jmp) sel_tgt = pc_jmp;
    else if (beq) sel_tgt = pc_branch;
  end

  // Next-state: PC/redirect buffer and RAS bookkeeping.
  always_comb begin
    state_n = state;
    pc_n    = pc;
    tgt_n   = tgt_q;
    ras_we  = 1'b0;
    waddr   = ptr;
    ptr_n   = ptr;
    cnt_n   = ras_count;
    top_n   = ras_top;
    uf_n    = 1'b0;

    if (!stall) begin
      if (state == S_PEND) begin
        pc_n    = tgt_q;
        state_n = S_RUN;
      end else begin
        pc_n = sel_tgt;
      end

      if (link && ret && ras_count != '0) begin
        ras_we = 1'b1;
        top_n  = link_addr;
      end else if (link) begin
        // A full stack overwrites its oldest slot, which is the one after top.
        ras_we = 1'b1;
        waddr  = ptr_inc;
        ptr_n  = ptr_inc;
        top_n  = link_addr;
        if (ras_count != CNT_W'(RAS_DEPTH)) cnt_n = ras_count + CNT_W'(1);
      end else if (ret) begin
        if (ras_count == '0) begin
          uf_n = 1'b1;
        end else begin
          ptr_n = ptr_dec;
          cnt_n = ras_count - CNT_W'(1);
          top_n = (ras_count == CNT_W'(1)) ? '0 : ras_mem[ptr_dec];
        end
      end
    end else if (state == S_RUN && redirect) begin
      tgt_n   = sel_tgt;
      state_n = S_PEND;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_RUN;
      pc            <= RESET_VEC;
      tgt_q         <= '0;
      ptr           <= '0;
      ras_count     <= '0;
      ras_top       <= '0;
      ras_underflow <= 1'b0;
    end else begin
      state         <= state_n;
      pc            <= pc_n;
      tgt_q         <= tgt_n;
      ptr           <= ptr_n;
      ras_count     <= cnt_n;
      ras_top       <= top_n;
      ras_underflow <= uf_n;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < RAS_DEPTH; i++) ras_mem[i] <= '0;
    end else if (ras_we) begin
      ras_mem[waddr] <= link_addr;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: queue-based reference model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_pc_sequencer;

  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] INCV  = 32'd4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall, beq, jmp, jr, link, ret;
  logic [31:0] pc_branch, pc_jmp, pc_reg, link_addr;
  logic [31:0] pc, pc_plus, ras_top;
  logic        pending, ras_underflow;
  logic [2:0]  ras_count;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  pc_sequencer #(.WIDTH(32), .RESET_VEC(32'h0), .INC(4), .RAS_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .stall(stall), .beq(beq), .pc_branch(pc_branch),
    .jmp(jmp), .pc_jmp(pc_jmp), .jr(jr), .pc_reg(pc_reg), .link(link),
    .link_addr(link_addr), .ret(ret), .pc(pc), .pc_plus(pc_plus),
    .pending(pending), .ras_top(ras_top), .ras_count(ras_count),
    .ras_underflow(ras_underflow)
  );

  always #5 clk = ~clk;

  // Reference model: PC, one buffered redirect, RAS as a bounded queue.
  logic [31:0] m_pc = 32'h0;
  logic [31:0] m_buf = 32'h0;
  bit          m_pend = 1'b0;
  bit          m_uf = 1'b0;
  logic [31:0] m_ras[$];

  always @(posedge clk or posedge rst) begin
    logic [31:0] tgt;
    if (rst) begin
      m_pc = 32'h0; m_pend = 1'b0; m_uf = 1'b0; m_buf = 32'h0;
      m_ras.delete();
    end else begin
      tgt = jr ? pc_reg : jmp ? pc_jmp : beq ? pc_branch : m_pc + INCV;
      m_uf = 1'b0;
      if (!stall) begin
        if (m_pend) begin m_pc = m_buf; m_pend = 1'b0; end
        else m_pc = tgt;
        if (link && ret && m_ras.size() > 0) m_ras[m_ras.size()-1] = link_addr;
        else if (link) begin
          m_ras.push_back(link_addr);
          if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
        end else if (ret) begin
          if (m_ras.size() == 0) m_uf = 1'b1;
          else void'(m_ras.pop_back());
        end
      end else if (!m_pend && (jr || jmp || beq)) begin
        m_buf = tgt; m_pend = 1'b1;
      end
    end
  end

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle model comparison, away from the active edge.
  always @(negedge clk) begin
    logic [31:0] e_top, e_plus;
    if (chk_en && !rst) begin
      e_top  = (m_ras.size() > 0) ? m_ras[m_ras.size()-1] : 32'h0;
      e_plus = m_pc + INCV;
      cmp("model_pc", pc, m_pc);
      cmp("model_pc_plus", pc_plus, e_plus);
      cmp("model_pending", 32'(pending), 32'(m_pend));
      cmp("model_ras_top", ras_top, e_top);
      cmp("model_ras_count", 32'(ras_count), 32'(m_ras.size()));
      cmp("model_ras_underflow", 32'(ras_underflow), 32'(m_uf));
    end
  end

  task automatic idle();
    stall = 0; beq = 0; jmp = 0; jr = 0; link = 0; ret = 0;
    pc_branch = '0; pc_jmp = '0; pc_reg = '0; link_addr = '0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic push(input logic [31:0] a);
    idle(); link = 1; link_addr = a; tick();
  endtask

  task automatic pop();
    idle(); ret = 1; tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    #12;
    cmp("rst_pc", pc, 32'h0);
    cmp("rst_pending", 32'(pending), 32'h0);
    cmp("rst_ras_count", 32'(ras_count), 32'h0);
    cmp("rst_ras_top", ras_top, 32'h0);
    cmp("rst_underflow", 32'(ras_underflow), 32'h0);
    @(posedge clk); #1;
    rst = 0; chk_en = 1;

    // Sequential fetch after reset.
    tick(); cmp("seq_pc1", pc, 32'h4);
    tick(); cmp("seq_pc2", pc, 32'h8);
    tick(); cmp("seq_pc3", pc, 32'hC);
    cmp("seq_pc_plus", pc_plus, 32'h10);

    // Priority jr > jmp > beq, then jmp > beq.
    jr = 1; pc_reg = 32'h100; jmp = 1; pc_jmp = 32'h200; beq = 1; pc_branch = 32'h300;
    tick(); cmp("prio_jr", pc, 32'h100);
    idle(); jmp = 1; pc_jmp = 32'h200; beq = 1; pc_branch = 32'h300;
    tick(); cmp("prio_jmp", pc, 32'h200);
    idle(); beq = 1; pc_branch = 32'h300;
    tick(); cmp("prio_beq", pc, 32'h300);
    idle(); jr = 1; pc_reg = 32'h100;
    tick();

    // Stall buffers the first redirect; older redirect wins on release.
    idle(); stall = 1; jmp = 1; pc_jmp = 32'h40;
    tick(); cmp("stall_hold_pc", pc, 32'h100);
    cmp("stall_pending", 32'(pending), 32'h1);
    idle(); stall = 1; beq = 1; pc_branch = 32'h80;
    tick(); tick();
    cmp("stall2_pc", pc, 32'h100);
    cmp("stall2_pending", 32'(pending), 32'h1);
    idle(); beq = 1; pc_branch = 32'hC0;
    tick(); cmp("release_pc", pc, 32'h40);
    cmp("release_pending", 32'(pending), 32'h0);
    idle(); tick(); cmp("after_release_pc", pc, 32'h44);
    idle(); stall = 1; tick();
    cmp("stall_noredir_pending", 32'(pending), 32'h0);
    cmp("stall_noredir_pc", pc, 32'h44);

    // RAS overflow wrap, pops, underflow.
    push(32'h10); push(32'h14); push(32'h18); push(32'h1C); push(32'h20);
    cmp("ras_full_count", 32'(ras_count), 32'h4);
    cmp("ras_full_top", ras_top, 32'h20);
    pop(); cmp("pop1_top", ras_top, 32'h1C);
    pop(); cmp("pop2_top", ras_top, 32'h18);
    pop(); cmp("pop3_top", ras_top, 32'h14);
    cmp("pop3_count", 32'(ras_count), 32'h1);
    pop(); cmp("pop4_top", ras_top, 32'h0);
    cmp("pop4_count", 32'(ras_count), 32'h0);
    cmp("pop4_uf", 32'(ras_underflow), 32'h0);
    pop(); cmp("pop5_uf", 32'(ras_underflow), 32'h1);
    cmp("pop5_count", 32'(ras_count), 32'h0);
    idle(); tick(); cmp("uf_pulse_end", 32'(ras_underflow), 32'h0);

    // Simultaneous link+ret, non-empty and empty.
    push(32'h10);
    idle(); link = 1; ret = 1; link_addr = 32'h44; tick();
    cmp("lr_top", ras_top, 32'h44);
    cmp("lr_count", 32'(ras_count), 32'h1);
    pop();
    idle(); link = 1; ret = 1; link_addr = 32'h50; tick();
    cmp("lr_empty_count", 32'(ras_count), 32'h1);
    cmp("lr_empty_top", ras_top, 32'h50);
    cmp("lr_empty_uf", 32'(ras_underflow), 32'h0);

    // Stall gates RAS operations.
    idle(); stall = 1; link = 1; link_addr = 32'h99; tick();
    cmp("stall_link_count", 32'(ras_count), 32'h1);
    pop();
    idle(); stall = 1; ret = 1; tick();
    cmp("stall_ret_uf", 32'(ras_underflow), 32'h0);
    idle(); tick();

    // PC wrap at all-ones boundary.
    idle(); jmp = 1; pc_jmp = 32'hFFFF_FFFC; tick();
    cmp("wrap_pc", pc, 32'hFFFF_FFFC);
    cmp("wrap_pc_plus", pc_plus, 32'h0);
    idle(); tick(); cmp("wrap_pc_next", pc, 32'h0);

    // Asynchronous reset with a buffered redirect.
    push(32'h70);
    idle(); stall = 1; jmp = 1; pc_jmp = 32'h80; tick();
    cmp("pre_rst_pending", 32'(pending), 32'h1);
    #2 rst = 1; #1;
    cmp("async_rst_pc", pc, 32'h0);
    cmp("async_rst_pending", 32'(pending), 32'h0);
    cmp("async_rst_count", 32'(ras_count), 32'h0);
    cmp("async_rst_top", ras_top, 32'h0);
    idle(); jmp = 1; pc_jmp = 32'h200; link = 1; link_addr = 32'h33;
    tick(); cmp("rst_wins_pc", pc, 32'h0);
    cmp("rst_wins_count", 32'(ras_count), 32'h0);
    idle(); rst = 0;
    tick(); cmp("post_rst_pc", pc, 32'h4);
    cmp("post_rst_pending", 32'(pending), 32'h0);
    tick(); cmp("post_rst_pc2", pc, 32'h8);

    @(negedge clk); #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 32, PC and target width in bits.
REQ-002 SHALL have parameter RESET_VEC, default 0, PC value after reset.
REQ-003 SHALL have parameter INC, default 4, sequential increment.
REQ-004 SHALL have parameter RAS_DEPTH, default 4, return-address-stack entries (>=2).
REQ-005 SHALL have ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- stall  in  1  hold PC this cycle.
- beq  in  1  branch taken.
- pc_branch  in  WIDTH  branch target.
- jmp  in  1  jump (j, jal).
- pc_jmp  in  WIDTH  jump target.
- jr  in  1  register jump (jr, jalr).
- pc_reg  in  WIDTH  register target.
- link  in  1  push link_addr onto the RAS (jal, jalr).
- link_addr  in  WIDTH  return address to push.
- ret  in  1  pop the RAS (jr $ra).
- pc  out  WIDTH  current PC, registered.
- pc_plus  out  WIDTH  pc + INC, combinational.
- pending  out  1  a redirect is buffered.
- ras_top  out  WIDTH  top RAS entry; 0 when empty.
- ras_count  out  clog2(RAS_DEPTH+1)  valid entries.
- ras_underflow  out  1  one-cycle pulse on a pop when empty.

Function
REQ-006 SHALL compute pc_plus = pc + INC modulo 2^WIDTH, so all-ones + INC wraps with no flag.
REQ-007 SHALL select the redirect target with priority jr > jmp > beq; with none asserted the next PC is pc_plus.
REQ-008 SHALL, when stall=0 and pending=0, load pc with the selected target on the next rising edge (1-cycle latency).
REQ-009 SHALL, when stall=0 and pending=1, load pc with the buffered target, clear pending, and discard any same-cycle redirect (the older redirect wins).
REQ-010 SHALL, when stall=1, hold pc unchanged.
REQ-011 SHALL, when stall=1 and pending=0 and any redirect is asserted, capture the highest-priority target into the buffer and set pending next cycle.
REQ-012 SHALL, when stall=1 and pending=1, keep the buffered target and ignore new redirects.
REQ-013 SHALL gate RAS operations (link, ret) with stall=0; under stall the RAS is unchanged and ras_underflow=0.
REQ-014 SHALL, on link only, push link_addr and increment ras_count.
REQ-015 SHALL, on link only with the RAS full, overwrite the oldest entry (circular), keep ras_count at RAS_DEPTH, and make link_addr the new top.
REQ-016 SHALL, on ret only with ras_count>0, remove the top entry and decrement ras_count.
REQ-017 SHALL, on ret with ras_count=0, leave the RAS unchanged and pulse ras_underflow for one cycle.
REQ-018 SHALL, on link and ret in the same cycle with a non-empty RAS, replace the top entry with link_addr and leave ras_count unchanged.
REQ-019 SHALL, on link and ret in the same cycle with an empty RAS, perform the push only, with no underflow.
REQ-020 SHALL keep the RAS independent of PC redirects; ret does not change pc by itself.

Reset
REQ-021 SHALL, while rst=1, asynchronously force pc=RESET_VEC, pending=0, ras_count=0, ras_top=0, ras_underflow=0, and clear the buffered target.
REQ-022 SHALL make reset asserted mid-stall or with pending=1 discard the buffered redirect; the first post-reset edge with stall=0 loads RESET_VEC+INC (or a redirect target).
REQ-023 SHALL make reset win over all same-cycle inputs.

Verification
REQ-024 SHALL pass this scenario: release reset with no inputs -> pc = 0, 4, 8, 12 on successive edges.
REQ-025 SHALL pass this scenario: jr=1 (pc_reg=0x100), jmp=1 (pc_jmp=0x200), beq=1 (pc_branch=0x300) in one cycle -> pc=0x100 next edge.
REQ-026 SHALL pass this scenario: stall=1 with jmp=1 (0x40), then stall held 2 cycles with beq=1 (0x80), then stall=0 with beq=1 (0xC0) -> pc unchanged, pending=1, then pc=0x40, pending=0.
REQ-027 SHALL pass this scenario: RAS_DEPTH=4, push 0x10, 0x14, 0x18, 0x1C, 0x20 -> ras_count=4, ras_top=0x20; then four pops -> tops 0x1C, 0x18, 0x14, then empty; a fifth pop -> ras_underflow pulse, count 0.
REQ-028 SHALL pass this scenario: RAS holding 0x10, link=1 and ret=1 with link_addr=0x44 -> ras_top=0x44, ras_count=1; link=1 and ret=1 on an empty RAS -> count=1, no underflow.
REQ-029 SHALL pass this scenario: WIDTH=32 with pc=0xFFFFFFFC, no redirect -> pc=0x00000000; assert rst with pending=1 -> pc=RESET_VEC, pending=0 immediately, without waiting for a clock edge.
